// File: rtl/pokey_clk_en_gen.sv
// pokey_clk_en_gen: 1.79 MHz enp/enn strobes plus 64 kHz/15 kHz base-clock enables (POKEY_EXTCLK_EN selects external clock input)
module pokey_clk_en_gen #(
  parameter int ACC_W     = 24,
  parameter int PHASE_INC = 1201108,
  parameter int DIV64     = 28,
  parameter int DIV15     = 114
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
`ifdef POKEY_EXTCLK_EN
  input  logic ext_clk179,
`endif
  output logic clk179,
  output logic enp,
  output logic enn,
  output logic en64,
  output logic en15
);
  logic [4:0] cnt64;
  logic [6:0] cnt15;
  logic       wrap64, wrap15;
`ifdef POKEY_EXTCLK_EN
  logic [2:0] sync;
  // two-flop synchronizer followed by a previous-sample flop for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[1:0], ext_clk179};
  assign clk179 = sync[1];
  assign enp    = sync[1] & ~sync[2];
  assign enn    = ~sync[1] & sync[2];
`else
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(PHASE_INC);
  // accumulator carry flips the phase; the direction of the flip selects which strobe fires next cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc    <= '0;
      clk179 <= 1'b0;
      enp    <= 1'b0;
      enn    <= 1'b0;
    end else begin
      acc    <= sum[ACC_W-1:0];
      clk179 <= clk179 ^ sum[ACC_W];
      enp    <= sum[ACC_W] & ~clk179;
      enn    <= sum[ACC_W] & clk179;
    end
`endif
  assign wrap64 = enn && cnt64 == 5'(DIV64 - 1);
  assign wrap15 = enn && cnt15 == 7'(DIV15 - 1);
  assign en64   = wrap64 & ~init;
  assign en15   = wrap15 & ~init;
  // base-clock dividers count enn pulses; init holds them at zero and wins over a wrap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt64 <= '0;
      cnt15 <= '0;
    end else begin
      cnt64 <= (init || wrap64) ? '0 : cnt64 + 5'(enn);
      cnt15 <= (init || wrap15) ? '0 : cnt15 + 7'(enn);
    end
endmodule

// File: tb/tb_pokey_clk_en_gen.sv
// tb_pokey_clk_en_gen: randomized init stimulus checked every cycle against an arithmetic phase/divider model
module tb_pokey_clk_en_gen;
  localparam int    ACC_W = 24;
  localparam longint INC  = 1201108;
  localparam int    DIV64 = 28;
  localparam int    DIV15 = 114;
  logic clk = 0, reset = 1, init = 0, ext = 0;
  logic clk179, enp, enn, en64, en15;
  int checks = 0, errors = 0;
  longint k = 0, e64 = 0, e15 = 0;
  longint last_enn_k = -1, last_enp_k = -1;
  int last_strobe = 0, n64 = 0, n15 = 0, cnt_enn = 0, cnt_enp = 0, tot64 = 0, tot15 = 0;
  bit seen_enp = 0, found;
  int exp_cnt;

  pokey_clk_en_gen dut (
    .clk(clk),
    .reset(reset),
    .init(init),
`ifdef POKEY_EXTCLK_EN
    .ext_clk179(ext),
`endif
    .clk179(clk179),
    .enp(enp),
    .enn(enn),
    .en64(en64),
    .en15(en15)
  );

  always #10 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_rng(string nm, longint act, longint lo, longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endfunction

  // number of accumulator overflows after n clock edges since reset release
  function automatic longint ncar(longint n);
    return (n * INC) >> ACC_W;
  endfunction
  function automatic bit m_step(longint n);
    return n > 0 && ncar(n) != ncar(n - 1);
  endfunction
  function automatic bit m_enp(longint n);
    return m_step(n) && ncar(n) % 2 == 1;
  endfunction
  function automatic bit m_enn(longint n);
    return m_step(n) && ncar(n) % 2 == 0;
  endfunction
  function automatic bit m_clk(longint n);
    return ncar(n) % 2 == 1;
  endfunction

  // model state: edges since release and enn pulses counted since the last divider clear
  always @(posedge clk) begin
    if (reset) begin
      k = 0; e64 = 0; e15 = 0;
    end else begin
      if (init) begin
        e64 = 0; e15 = 0;
      end else if (m_enn(k)) begin
        e64++; e15++;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {clk179, enp, enn, en64, en15}, 0);
      last_strobe = 0; last_enn_k = -1; last_enp_k = -1;
      n64 = 0; n15 = 0; seen_enp = 0; cnt_enn = 0; cnt_enp = 0;
    end else begin
      chk("clk179", clk179, m_clk(k));
      chk("enp", enp, m_enp(k));
      chk("enn", enn, m_enn(k));
      chk("en64", en64, !init && m_enn(k) && (e64 + 1) % DIV64 == 0);
      chk("en15", en15, !init && m_enn(k) && (e15 + 1) % DIV15 == 0);
      chk("enp_and_enn", enp & enn, 0);
      chk("en64_without_enn", en64 & ~enn, 0);
      chk("en15_without_enn", en15 & ~enn, 0);
      if (init) chk("en_during_init", en64 | en15, 0);
      if (enp) begin
        if (!seen_enp) chk("first_enp_cycle", k + 1, 15);
        seen_enp = 1;
        chk("alternate_enp", last_strobe == 1, 0);
        last_strobe = 1; last_enp_k = k; cnt_enp++;
      end
      if (enn) begin
        chk("alternate_enn", last_strobe, 1);
        if (last_enn_k >= 0) chk_rng("enn_interval", k - last_enn_k, 27, 28);
        chk_rng("enp_to_enn", k - last_enp_k, 13, 14);
        last_strobe = 2; last_enn_k = k; cnt_enn++;
        if (!init) begin n64++; n15++; end
      end
      if (init) begin n64 = 0; n15 = 0; end
      if (en64) begin chk("enn_per_en64", n64, DIV64); n64 = 0; tot64++; end
      if (en15) begin chk("enn_per_en15", n15, DIV15); n15 = 0; tot15++; end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #5 reset = 0;
    repeat (50000) @(posedge clk);
    #1;
    exp_cnt = $rtoi(50000.0 * 1789772.5 / 50.0e6 + 0.5);
    chk_rng("enn_count_50k", cnt_enn, exp_cnt - 1, exp_cnt + 1);
    chk_rng("enp_count_50k", cnt_enp, cnt_enn - 1, cnt_enn + 1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (enp) begin found = 1; break; end
    end
    chk("enp_before_reset", found, 1);
    repeat (3) @(posedge clk);
    #5 reset = 1;
    #1 chk("reset_async_clear", {clk179, enp, enn, en64, en15}, 0);
    repeat (3) @(posedge clk);
    #5 reset = 0;
    repeat (2000) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(100, 1500)) @(posedge clk);
      #5 init = 1;
      repeat (i == 0 ? 500 : $urandom_range(1, 500)) @(posedge clk);
      #5 init = 0;
    end
    repeat (4000) @(posedge clk);
    #1;
    chk_rng("en64_pulses_seen", tot64, 1, 100000);
    chk_rng("en15_pulses_seen", tot15, 1, 100000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
